// File: rtl/baccarat_round_ctrl.sv
// baccarat_round_ctrl: sequences one baccarat round (deal order, natural and
// third-card rules, result declaration) between the step key, the card source
// and the card/score datapath.
// Optional feature: define ROUND_TALLY_EN to add saturating CNT_W-bit
// p_wins / d_wins / ties counters.
module baccarat_round_ctrl
`ifdef ROUND_TALLY_EN
   #(parameter int unsigned CNT_W = 8)
`endif
(
   input  logic             slow_clock,
   input  logic             reset,
   input  logic             step,
   input  logic             card_ack,
   input  logic [3:0]       pscore,
   input  logic [3:0]       dscore,
   input  logic [3:0]       pcard3,
   output logic             card_req,
   output logic             new_round,
   output logic             load_pcard1,
   output logic             load_pcard2,
   output logic             load_pcard3,
   output logic             load_dcard1,
   output logic             load_dcard2,
   output logic             load_dcard3,
   output logic             player_win,
   output logic             dealer_win,
   output logic             done
`ifdef ROUND_TALLY_EN
   ,
   output logic [CNT_W-1:0] p_wins,
   output logic [CNT_W-1:0] d_wins,
   output logic [CNT_W-1:0] ties
`endif
);

   typedef enum logic [3:0] {
      IDLE, P1, D1, P2, D2, CHECK, P3, D3, RESULT
   } state_t;

   // Sub-steps of every deal state.
   typedef enum logic [1:0] {
      PH_WAIT, PH_REQ, PH_LOAD, PH_SETTLE
   } phase_t;

   state_t state;
   phase_t phase;
   logic   natural;
   logic   dealer_draw;
   logic   enter_result;

   // Dealer third-card rule, given the dealer score and the player's third card.
   function automatic logic dealer_draws(input logic [3:0] d, input logic [3:0] c3);
      case (d)
         4'd0, 4'd1, 4'd2: return 1'b1;
         4'd3:             return c3 != 4'd8;
         4'd4:             return (c3 >= 4'd2) && (c3 <= 4'd7);
         4'd5:             return (c3 >= 4'd4) && (c3 <= 4'd7);
         4'd6:             return (c3 >= 4'd6) && (c3 <= 4'd7);
         default:          return 1'b0;
      endcase
   endfunction

   // Decision terms: the round ends at CHECK (natural or both stand), after P3
   // when the dealer stands, or after D3.
   always_comb begin
      natural      = (pscore >= 4'd8) || (dscore >= 4'd8);
      dealer_draw  = dealer_draws(dscore, pcard3);
      enter_result = 1'b0;
      if (state == CHECK)
         enter_result = natural || ((pscore > 4'd5) && (dscore > 4'd5));
      else if (phase == PH_SETTLE && state == P3)
         enter_result = !dealer_draw;
      else if (phase == PH_SETTLE && state == D3)
         enter_result = 1'b1;
   end

   // Round FSM with registered strobes, request and result flags.
   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         phase       <= PH_WAIT;
         card_req    <= 1'b0;
         new_round   <= 1'b0;
         load_pcard1 <= 1'b0;
         load_pcard2 <= 1'b0;
         load_pcard3 <= 1'b0;
         load_dcard1 <= 1'b0;
         load_dcard2 <= 1'b0;
         load_dcard3 <= 1'b0;
         player_win  <= 1'b0;
         dealer_win  <= 1'b0;
         done        <= 1'b0;
      end else begin
         new_round   <= 1'b0;
         load_pcard1 <= 1'b0;
         load_pcard2 <= 1'b0;
         load_pcard3 <= 1'b0;
         load_dcard1 <= 1'b0;
         load_dcard2 <= 1'b0;
         load_dcard3 <= 1'b0;

         case (state)
            IDLE, RESULT: begin
               if (step) begin
                  new_round  <= 1'b1;
                  player_win <= 1'b0;
                  dealer_win <= 1'b0;
                  done       <= 1'b0;
                  state      <= P1;
                  phase      <= PH_WAIT;
               end
            end
            CHECK: begin
               phase <= PH_WAIT;
               if (enter_result)
                  state <= RESULT;
               else if (pscore <= 4'd5)
                  state <= P3;
               else
                  state <= D3;
            end
            default: begin
               case (phase)
                  PH_WAIT: begin
                     if (step) begin
                        card_req <= 1'b1;
                        phase    <= PH_REQ;
                     end
                  end
                  PH_REQ: begin
                     // step is deliberately ignored while a card is outstanding
                     if (card_ack) begin
                        card_req <= 1'b0;
                        phase    <= PH_LOAD;
                        case (state)
                           P1:      load_pcard1 <= 1'b1;
                           D1:      load_dcard1 <= 1'b1;
                           P2:      load_pcard2 <= 1'b1;
                           D2:      load_dcard2 <= 1'b1;
                           P3:      load_pcard3 <= 1'b1;
                           D3:      load_dcard3 <= 1'b1;
                           default: ;
                        endcase
                     end
                  end
                  PH_LOAD: phase <= PH_SETTLE;
                  default: begin
                     phase <= PH_WAIT;
                     case (state)
                        P1:      state <= D1;
                        D1:      state <= P2;
                        P2:      state <= D2;
                        D2:      state <= CHECK;
                        P3:      state <= enter_result ? RESULT : D3;
                        D3:      state <= RESULT;
                        default: state <= IDLE;
                     endcase
                  end
               endcase
            end
         endcase

         // Result is captured on the same edge the FSM enters RESULT.
         if (enter_result) begin
            player_win <= pscore > dscore;
            dealer_win <= dscore > pscore;
            done       <= 1'b1;
            if (pscore == dscore) begin
               player_win <= 1'b1;
               dealer_win <= 1'b1;
            end
         end
      end
   end

`ifdef ROUND_TALLY_EN
   // Saturating win/tie tallies; survive new_round, cleared only by reset.
   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         p_wins <= '0;
         d_wins <= '0;
         ties   <= '0;
      end else if (enter_result) begin
         if (pscore > dscore) begin
            if (p_wins != {CNT_W{1'b1}}) p_wins <= p_wins + CNT_W'(1);
         end else if (dscore > pscore) begin
            if (d_wins != {CNT_W{1'b1}}) d_wins <= d_wins + CNT_W'(1);
         end else begin
            if (ties != {CNT_W{1'b1}}) ties <= ties + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Directed bench for baccarat_round_ctrl with a small card/score datapath model.
module tb_baccarat_round_ctrl;

   logic       clk;
   logic       rst;
   logic       step;
   logic       card_ack;
   logic [3:0] pscore, dscore, pcard3;
   logic       card_req, new_round;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic       player_win, dealer_win, done;
`ifdef ROUND_TALLY_EN
   logic [7:0] p_wins, d_wins, ties;
   int         exp_p, exp_d, exp_t;
`endif

   int total = 0;
   int bad   = 0;

   logic [3:0] card_val;
   logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;
   int         n_loads = 0, n_p3 = 0, n_d3 = 0, n_multi = 0;
   int         base, base_p3, base_d3;

   baccarat_round_ctrl dut (
      .slow_clock (clk),
      .reset      (rst),
      .step       (step),
      .card_ack   (card_ack),
      .pscore     (pscore),
      .dscore     (dscore),
      .pcard3     (pcard3),
      .card_req   (card_req),
      .new_round  (new_round),
      .load_pcard1(load_pcard1),
      .load_pcard2(load_pcard2),
      .load_pcard3(load_pcard3),
      .load_dcard1(load_dcard1),
      .load_dcard2(load_dcard2),
      .load_dcard3(load_dcard3),
      .player_win (player_win),
      .dealer_win (dealer_win),
      .done       (done)
`ifdef ROUND_TALLY_EN
      ,
      .p_wins     (p_wins),
      .d_wins     (d_wins),
      .ties       (ties)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Card register model of the datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || new_round) begin
         pc1 <= '0; pc2 <= '0; pc3 <= '0;
         dc1 <= '0; dc2 <= '0; dc3 <= '0;
      end else begin
         if (load_pcard1) pc1 <= card_val;
         if (load_pcard2) pc2 <= card_val;
         if (load_pcard3) pc3 <= card_val;
         if (load_dcard1) dc1 <= card_val;
         if (load_dcard2) dc2 <= card_val;
         if (load_dcard3) dc3 <= card_val;
      end
   end

   assign pscore = 4'((5'(pc1) + 5'(pc2) + 5'(pc3)) % 5'd10);
   assign dscore = 4'((5'(dc1) + 5'(dc2) + 5'(dc3)) % 5'd10);
   assign pcard3 = pc3;

   // Strobe counters sampled away from the active edge.
   always_ff @(negedge clk) begin
      n_loads <= n_loads + $countones({load_pcard1, load_pcard2, load_pcard3,
                                       load_dcard1, load_dcard2, load_dcard3});
      if (load_pcard3) n_p3 <= n_p3 + 1;
      if (load_dcard3) n_d3 <= n_d3 + 1;
      if ($countones({load_pcard1, load_pcard2, load_pcard3,
                      load_dcard1, load_dcard2, load_dcard3}) > 1)
         n_multi <= n_multi + 1;
   end

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
`ifdef ROUND_TALLY_EN
      exp_p = 0; exp_d = 0; exp_t = 0;
`endif
   endtask

   task automatic start_round();
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
   endtask

   // One deal state: step, wait for the request, acknowledge, let it settle.
   task automatic deal(input logic [3:0] v);
      int n;
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      n = 0;
      while (card_req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (card_req !== 1'b1) begin
         total++; bad++;
         $display("FAIL card_req_timeout: card_req=%b required=1", card_req);
      end else begin
         card_val = v;
         card_ack = 1'b1;
         @(negedge clk) card_ack = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

`ifdef ROUND_TALLY_EN
   task automatic check_tallies(input string tag);
      total++;
      if ({p_wins, d_wins, ties} !== {8'(exp_p), 8'(exp_d), 8'(exp_t)}) begin
         bad++;
         $display("FAIL %s_tally: got p=%0d d=%0d t=%0d required p=%0d d=%0d t=%0d",
                  tag, p_wins, d_wins, ties, exp_p, exp_d, exp_t);
      end
   endtask
`endif

   task automatic test_reset();
      rst = 1'b1; step = 1'b0; card_ack = 1'b0; card_val = '0;
      @(negedge clk); @(negedge clk);
      total++;
      if ({card_req, new_round, load_pcard1, load_pcard2, load_pcard3, load_dcard1,
           load_dcard2, load_dcard3, player_win, dealer_win, done} !== 11'b0) begin
         bad++;
         $display("FAIL reset_outputs: outputs not all zero (card_req=%b done=%b)", card_req, done);
      end
      rst = 1'b0;
`ifdef ROUND_TALLY_EN
      exp_p = 0; exp_d = 0; exp_t = 0;
      check_tallies("reset");
`endif
      start_round();
      total++;
      if (new_round !== 1'b1) begin
         bad++; $display("FAIL idle_new_round: new_round=%b required=1", new_round);
      end
      @(negedge clk);
      total++;
      if (new_round !== 1'b0 || card_req !== 1'b0) begin
         bad++;
         $display("FAIL new_round_pulse: new_round=%b card_req=%b required 0 0", new_round, card_req);
      end
      do_reset();
   endtask

   task automatic test_natural();
      base = n_loads; base_p3 = n_p3;
      start_round();
      deal(4'd4); deal(4'd0); deal(4'd5); deal(4'd0);
      @(negedge clk); @(negedge clk);
      total++;
      if ({player_win, dealer_win, done} !== 3'b101) begin
         bad++;
         $display("FAIL natural_result: pw=%b dw=%b done=%b required 1 0 1", player_win, dealer_win, done);
      end
      total++;
      if (n_loads - base !== 4 || n_p3 - base_p3 !== 0) begin
         bad++;
         $display("FAIL natural_loads: loads=%0d p3=%0d required 4 0", n_loads - base, n_p3 - base_p3);
      end
`ifdef ROUND_TALLY_EN
      exp_p++;
      check_tallies("natural");
`endif
   endtask

   task automatic test_third_card();
      base = n_loads; base_d3 = n_d3;
      start_round();
      total++;
      if ({new_round, player_win, dealer_win, done} !== 4'b1000) begin
         bad++;
         $display("FAIL result_clear: nr=%b pw=%b dw=%b done=%b required 1 0 0 0",
                  new_round, player_win, dealer_win, done);
      end
      deal(4'd8); deal(4'd0); deal(4'd5); deal(4'd0);
      @(negedge clk); @(negedge clk);
      total++;
      if (done !== 1'b0 || card_req !== 1'b0) begin
         bad++;
         $display("FAIL check_to_p3: done=%b card_req=%b required 0 0", done, card_req);
      end
      deal(4'd7); deal(4'd4);
      @(negedge clk); @(negedge clk);
      total++;
      if ({player_win, dealer_win, done} !== 3'b011) begin
         bad++;
         $display("FAIL third_card_result: pw=%b dw=%b done=%b required 0 1 1", player_win, dealer_win, done);
      end
      total++;
      if (n_loads - base !== 6 || n_d3 - base_d3 !== 1) begin
         bad++;
         $display("FAIL third_card_loads: loads=%0d d3=%0d required 6 1", n_loads - base, n_d3 - base_d3);
      end
`ifdef ROUND_TALLY_EN
      exp_d++;
      check_tallies("third_card");
`endif
   endtask

   task automatic test_dealer_stand();
      base = n_loads; base_d3 = n_d3;
      start_round();
      deal(4'd2); deal(4'd3); deal(4'd0); deal(4'd0);
      @(negedge clk); @(negedge clk);
      deal(4'd8);
      @(negedge clk); @(negedge clk);
      total++;
      if ({player_win, dealer_win, done} !== 3'b011) begin
         bad++;
         $display("FAIL dealer_stand_result: pw=%b dw=%b done=%b required 0 1 1", player_win, dealer_win, done);
      end
      total++;
      if (n_loads - base !== 5 || n_d3 - base_d3 !== 0) begin
         bad++;
         $display("FAIL dealer_stand_loads: loads=%0d d3=%0d required 5 0", n_loads - base, n_d3 - base_d3);
      end
`ifdef ROUND_TALLY_EN
      exp_d++;
      check_tallies("dealer_stand");
`endif
   endtask

   task automatic test_player_stands();
      base = n_loads; base_p3 = n_p3;
      start_round();
      deal(4'd6); deal(4'd6); deal(4'd0); deal(4'd0);
      @(negedge clk); @(negedge clk);
      total++;
      if ({player_win, dealer_win, done} !== 3'b111) begin
         bad++;
         $display("FAIL tie_result: pw=%b dw=%b done=%b required 1 1 1", player_win, dealer_win, done);
      end
      total++;
      if (n_loads - base !== 4 || n_p3 - base_p3 !== 0) begin
         bad++;
         $display("FAIL tie_loads: loads=%0d p3=%0d required 4 0", n_loads - base, n_p3 - base_p3);
      end
`ifdef ROUND_TALLY_EN
      exp_t++;
      check_tallies("tie");
`endif
   endtask

   task automatic test_dealer_six();
      base_d3 = n_d3;
      start_round();
      deal(4'd0); deal(4'd6); deal(4'd1); deal(4'd0);
      @(negedge clk); @(negedge clk);
      deal(4'd6); deal(4'd0);
      @(negedge clk); @(negedge clk);
      total++;
      if ({player_win, dealer_win, done, 4'(n_d3 - base_d3)} !== {3'b101, 4'd1}) begin
         bad++;
         $display("FAIL dealer_six: pw=%b dw=%b done=%b d3=%0d required 1 0 1 1",
                  player_win, dealer_win, done, n_d3 - base_d3);
      end
`ifdef ROUND_TALLY_EN
      exp_p++;
      check_tallies("dealer_six");
`endif
   endtask

   task automatic test_handshake();
      start_round();
      base = n_loads;
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step = (i % 2 == 0);
         @(negedge clk);
         total++;
         if (card_req !== 1'b1) begin
            bad++; $display("FAIL req_hold_%0d: card_req=%b required=1", i, card_req);
         end
      end
      step = 1'b0;
      total++;
      if (n_loads - base !== 0) begin
         bad++; $display("FAIL no_load_without_ack: loads=%0d required 0", n_loads - base);
      end
      card_val = 4'd3; card_ack = 1'b1; step = 1'b1;
      @(negedge clk) begin card_ack = 1'b0; step = 1'b0; end
      total++;
      if ({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
           card_req} !== 7'b1000000) begin
         bad++;
         $display("FAIL ack_load: strobes=%b%b%b%b%b%b card_req=%b required 100000 0",
                  load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3, card_req);
      end
      @(negedge clk);
      total++;
      if (load_pcard1 !== 1'b0) begin
         bad++; $display("FAIL load_one_cycle: load_pcard1=%b required 0", load_pcard1);
      end
      @(negedge clk); @(negedge clk);
      card_ack = 1'b1;
      @(negedge clk) card_ack = 1'b0;
      @(negedge clk); @(negedge clk);
      total++;
      if (n_loads - base !== 1 || card_req !== 1'b0) begin
         bad++;
         $display("FAIL stray_ack: loads=%0d card_req=%b required 1 0", n_loads - base, card_req);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      start_round();
      deal(4'd1); deal(4'd2); deal(4'd3);
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      total++;
      if (card_req !== 1'b1) begin
         bad++; $display("FAIL d2_req: card_req=%b required 1", card_req);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({card_req, new_round, load_pcard1, load_pcard2, load_pcard3, load_dcard1,
           load_dcard2, load_dcard3, player_win, dealer_win, done} !== 11'b0) begin
         bad++; $display("FAIL mid_reset_outputs: card_req=%b done=%b required 0 0", card_req, done);
      end
`ifdef ROUND_TALLY_EN
      exp_p = 0; exp_d = 0; exp_t = 0;
      check_tallies("mid_reset");
`endif
      rst = 1'b0;
      start_round();
      total++;
      if (new_round !== 1'b1 || card_req !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: new_round=%b card_req=%b required 1 0", new_round, card_req);
      end
      do_reset();
   endtask

`ifdef ROUND_TALLY_EN
   task automatic test_saturation();
      do_reset();
      for (int r = 0; r < 256; r++) begin
         start_round();
         deal(4'd9); deal(4'd0); deal(4'd0); deal(4'd0);
         @(negedge clk); @(negedge clk);
      end
      exp_p = 255;
      check_tallies("saturation");
   endtask
`endif

   initial begin
      test_reset();
      test_natural();
      test_third_card();
      test_dealer_stand();
      test_player_stands();
      test_dealer_six();
      test_handshake();
      test_reset_mid();
`ifdef ROUND_TALLY_EN
      test_saturation();
`endif
      total++;
      if (n_multi !== 0) begin
         bad++; $display("FAIL load_onehot: overlapping strobe cycles=%0d required 0", n_multi);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
